// File: rtl/axil_pkg.sv
// Shared types and response encodings for the AXI4-Lite master bridge.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WAIT_B,
    RD_ADDR,
    WAIT_R,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both report as an error to the client.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b0;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite initiator fed from a valid/ready request port.
// Define AXIL_ADDR_CHECK_EN to reject requests outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES).
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [2:0]            PROT       = 3'b000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH:0]   SIZE_BYTES = 'h1_0000,
  localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,

  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    addr_in_window;

`ifdef AXIL_ADDR_CHECK_EN
  // One extra bit keeps BASE_ADDR+SIZE_BYTES from wrapping at the top of the map.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + SIZE_BYTES;

  assign addr_in_window = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
`else
  assign addr_in_window = 1'b1;
`endif

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign m_axil_bready  = (state_q == WAIT_B);
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = (state_q == RD_ADDR);
  assign m_axil_rready  = (state_q == WAIT_R);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!addr_in_window) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_write) begin
            state_d = WR_ADDR_DATA;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      // AW and W complete independently; the later of the two moves us on.
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q | (m_axil_awvalid & m_axil_awready);
        w_done_d  = w_done_q  | (m_axil_wvalid  & m_axil_wready);
        if (aw_done_d && w_done_d) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (m_axil_bvalid) begin
          rdata_d = '0;
          err_d   = resp_is_err(m_axil_bresp);
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          err_d   = resp_is_err(m_axil_rresp);
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench for axil_master_bridge with a delay-configurable AXI-Lite responder.
// Define AXIL_ADDR_CHECK_EN to also exercise the address window.
module tb_axil_master_bridge;
  import axil_pkg::*;

`ifdef AXIL_ADDR_CHECK_EN
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [32:0] SIZE = 33'h100;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [32:0] SIZE = 33'h1_0000;
`endif
  localparam logic [31:0] A0 = BASE + 32'h10;

  logic        aclk, aresetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;

  axil_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000),
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    time         t_acc;
  } exp_t;
  exp_t sb[$];

  int check_count = 0;
  int pass_count  = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  logic [31:0] rdata_cfg = '0;

  int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, resp_seen = 0, proto_err = 0;
  time aw_time, w_time;
  logic [31:0] aw_addr_seen, ar_addr_seen, w_data_seen;
  logic [3:0]  w_strb_seen;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Responder: decides readies/valids just after each rising edge from the DUT's settled outputs.
  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
    m_axil_bvalid  = 1'b0; m_axil_rvalid = 1'b0;
    m_axil_bresp   = RESP_OKAY; m_axil_rresp = RESP_OKAY; m_axil_rdata = '0;
    forever begin
      @(posedge aclk); #1;
      if (m_axil_awvalid) begin m_axil_awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin m_axil_awready = 1'b0; aw_wait = 0; end
      if (m_axil_wvalid) begin m_axil_wready = (w_wait >= w_delay); w_wait++; end
      else begin m_axil_wready = 1'b0; w_wait = 0; end
      if (m_axil_arvalid) begin m_axil_arready = (ar_wait >= ar_delay); ar_wait++; end
      else begin m_axil_arready = 1'b0; ar_wait = 0; end
      if (m_axil_bready) begin m_axil_bvalid = (b_wait >= b_delay); m_axil_bresp = bresp_cfg; b_wait++; end
      else begin m_axil_bvalid = 1'b0; b_wait = 0; end
      if (m_axil_rready) begin
        m_axil_rvalid = (r_wait >= r_delay); m_axil_rresp = rresp_cfg; m_axil_rdata = rdata_cfg; r_wait++;
      end else begin m_axil_rvalid = 1'b0; r_wait = 0; end
    end
  end

  // Monitor: counts handshakes, polices valid stability and retires scoreboard entries.
  initial begin
    logic p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    exp_t e;
    p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    forever begin
      @(negedge aclk);
      if (p_aw && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr)) proto_err++;
      if (p_w && (!m_axil_wvalid || m_axil_wdata !== p_wdata || m_axil_wstrb !== p_wstrb)) proto_err++;
      if (p_ar && (!m_axil_arvalid || m_axil_araddr !== p_araddr)) proto_err++;
      if (m_axil_awvalid && m_axil_awready) begin
        aw_hs++; aw_time = $time; aw_addr_seen = m_axil_awaddr;
        checkOutput("awprot", m_axil_awprot, 3'b000);
      end
      if (m_axil_wvalid && m_axil_wready) begin
        w_hs++; w_time = $time; w_data_seen = m_axil_wdata; w_strb_seen = m_axil_wstrb;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_hs++; ar_addr_seen = m_axil_araddr;
        checkOutput("arprot", m_axil_arprot, 3'b000);
      end
      if (m_axil_bvalid && m_axil_bready) b_hs++;
      if (m_axil_rvalid && m_axil_rready) r_hs++;
      p_aw = m_axil_awvalid && !m_axil_awready && aresetn;
      p_w  = m_axil_wvalid  && !m_axil_wready  && aresetn;
      p_ar = m_axil_arvalid && !m_axil_arready && aresetn;
      p_awaddr = m_axil_awaddr; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb; p_araddr = m_axil_araddr;
      if (resp_valid) begin
        resp_seen++;
        checkOutput("sb_pending", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", resp_err, e.err);
          if (e.lat >= 0) checkOutput("latency", ($time - e.t_acc) / 10, e.lat);
        end
      end
    end
  end

  // Drives one request, pushes its expected response at acceptance, optionally waits for completion.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat, input bit wait_resp);
    bit accepted;
    int start;
    accepted = 1'b0;
    start = resp_seen;
    @(posedge aclk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge aclk);
      if (req_ready) begin
        accepted = 1'b1;
        start = resp_seen;
        sb.push_back('{exp_rdata, exp_err, exp_lat, $time});
      end
      @(posedge aclk); #1;
    end
    req_valid = 1'b0;
    checkOutput("req_accept", accepted, 1'b1);
    if (wait_resp && accepted) begin
      for (int n = 0; n < 100 && resp_seen == start; n++) begin
        @(posedge aclk); #1;
      end
      checkOutput("resp_arrived", (resp_seen != start), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int aw0, w0, b0, ar0, r0, rs;
    aresetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #12;
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_awvalid", m_axil_awvalid, 1'b0);
    checkOutput("rst_wvalid", m_axil_wvalid, 1'b0);
    checkOutput("rst_arvalid", m_axil_arvalid, 1'b0);
    checkOutput("rst_bready", m_axil_bready, 1'b0);
    checkOutput("rst_rready", m_axil_rready, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", resp_err, 1'b0);
    @(negedge aclk); aresetn = 1'b1;

    $display("[TB] write with AW/W ready immediately");
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    applyStimulus(1'b1, A0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3, 1'b1);
    checkOutput("t1_aw_hs", aw_hs - aw0, 1);
    checkOutput("t1_w_hs", w_hs - w0, 1);
    checkOutput("t1_b_hs", b_hs - b0, 1);
    checkOutput("t1_same_cycle", w_time, aw_time);
    checkOutput("t1_awaddr", aw_addr_seen, A0);
    checkOutput("t1_wdata", w_data_seen, 32'hDEADBEEF);
    checkOutput("t1_wstrb", w_strb_seen, 4'hF);

    $display("[TB] write with W ready 4 cycles after AW");
    w_delay = 4;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    applyStimulus(1'b1, A0 + 32'h4, 32'h12345678, 4'h3, 32'h0, 1'b0, 7, 1'b1);
    checkOutput("t2_aw_hs", aw_hs - aw0, 1);
    checkOutput("t2_w_hs", w_hs - w0, 1);
    checkOutput("t2_b_hs", b_hs - b0, 1);
    checkOutput("t2_w_lag", (w_time - aw_time) / 10, 4);
    checkOutput("t2_wdata", w_data_seen, 32'h12345678);
    checkOutput("t2_wstrb", w_strb_seen, 4'h3);
    w_delay = 0;

    $display("[TB] read with R delayed 5 cycles");
    r_delay = 5; rdata_cfg = 32'hCAFEF00D;
    ar0 = ar_hs; r0 = r_hs;
    applyStimulus(1'b0, A0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 8, 1'b1);
    checkOutput("t3_ar_hs", ar_hs - ar0, 1);
    checkOutput("t3_r_hs", r_hs - r0, 1);
    checkOutput("t3_araddr", ar_addr_seen, A0);
    r_delay = 0;

    $display("[TB] error responses then recovery");
    rresp_cfg = RESP_SLVERR; rdata_cfg = 32'h11112222;
    applyStimulus(1'b0, A0 + 32'h8, 32'h0, 4'h0, 32'h11112222, 1'b1, 3, 1'b1);
    bresp_cfg = RESP_DECERR;
    applyStimulus(1'b1, A0 + 32'hC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1, 3, 1'b1);
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; rdata_cfg = 32'h33334444;
    applyStimulus(1'b0, A0, 32'h0, 4'h0, 32'h33334444, 1'b0, 3, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("hold_rdata", resp_rdata, 32'h33334444);
    checkOutput("hold_err", resp_err, 1'b0);

    $display("[TB] reset while waiting for R");
    r_delay = 20; rdata_cfg = 32'h99998888;
    applyStimulus(1'b0, A0, 32'h0, 4'h0, 32'h99998888, 1'b0, -1, 1'b0);
    for (int n = 0; n < 20 && !m_axil_rready; n++) begin
      @(posedge aclk); #1;
    end
    checkOutput("rst_in_wait_r", m_axil_rready, 1'b1);
    rs = resp_seen;
    #3 aresetn = 1'b0;
    #1;
    checkOutput("arst_rready", m_axil_rready, 1'b0);
    checkOutput("arst_arvalid", m_axil_arvalid, 1'b0);
    checkOutput("arst_bready", m_axil_bready, 1'b0);
    checkOutput("arst_awvalid", m_axil_awvalid, 1'b0);
    checkOutput("arst_wvalid", m_axil_wvalid, 1'b0);
    checkOutput("arst_req_ready", req_ready, 1'b1);
    checkOutput("arst_resp_rdata", resp_rdata, 32'h0);
    sb.delete();
    repeat (3) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    checkOutput("arst_no_resp", resp_seen, rs);
    r_delay = 0; rdata_cfg = 32'h55AA55AA;
    applyStimulus(1'b0, A0 + 32'h8, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 3, 1'b1);

`ifdef AXIL_ADDR_CHECK_EN
    $display("[TB] address window checks");
    ar0 = ar_hs;
    applyStimulus(1'b0, BASE + 32'h100, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1);
    checkOutput("win_out_no_ar", ar_hs - ar0, 0);
    aw0 = aw_hs;
    applyStimulus(1'b1, BASE - 32'h4, 32'h77777777, 4'hF, 32'h0, 1'b1, 1, 1'b1);
    checkOutput("win_low_no_aw", aw_hs - aw0, 0);
    rdata_cfg = 32'h0BADF00D;
    ar0 = ar_hs;
    applyStimulus(1'b0, BASE + 32'hFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 3, 1'b1);
    checkOutput("win_in_ar", ar_hs - ar0, 1);
`else
    $display("[TB] high address goes to the bus");
    rdata_cfg = 32'h0BADF00D;
    ar0 = ar_hs;
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 3, 1'b1);
    checkOutput("high_ar", ar_hs - ar0, 1);
    checkOutput("high_araddr", ar_addr_seen, 32'hFFFF_FFFC);
`endif

    checkOutput("proto_errs", proto_err, 0);
    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
